mu0_ctrl: RTL
=============

MU0_CTRL -- requirements
Module: mu0_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles mem_req may stay high without mem_ack before error (range 1..255).
REQ-002 SHALL have parameter CNTW, default 16, width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leaves IDLE or HALT and begins fetching.
REQ-006 SHALL have port opcode  input  4  IR[15:12] from the datapath, valid from the cycle after ir_ld.
REQ-007 SHALL have port acc_zero  input  1  datapath accumulator equals 0.
REQ-008 SHALL have port acc_neg  input  1  datapath accumulator bit 15.
REQ-009 SHALL have port mem_ack  input  1  memory completes the current access.
REQ-010 SHALL have ports mem_req, mem_we, addr_sel (0=PC, 1=IR[11:0]), ir_ld, pc_inc, pc_ld (PC<=IR[11:0]), acc_ld  output  1 each  datapath/memory controls.
REQ-011 SHALL have port alu_fn  output  2  00 pass memory data, 01 ACC+mem, 10 ACC-mem.
REQ-012 SHALL have ports halted, error  output  1 each  status flags.
REQ-013 SHALL have port instr_cnt  output  CNTW  retired-instruction count.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, HALT, ERR.
REQ-015 IDLE: all controls 0; start=1 -> FETCH next cycle.
REQ-016 FETCH: mem_req=1, addr_sel=0, mem_we=0; in the cycle mem_req&mem_ack: ir_ld=1, pc_inc=1, -> DECODE.
REQ-017 DECODE (exactly one cycle): opcode 0/1/2/3 (LDA/STO/ADD/SUB) -> EXEC; 4 (JMP) pc_ld=1 -> FETCH; 5 (JGE) pc_ld=!acc_neg -> FETCH; 6 (JNE) pc_ld=!acc_zero -> FETCH; 7 (STP) -> HALT; 8..15 -> ERR.
REQ-018 EXEC: mem_req=1, addr_sel=1, mem_we=1 only for STO; in the ack cycle acc_ld=1 for LDA/ADD/SUB with alu_fn 00/01/10 respectively (alu_fn=00 otherwise), then -> FETCH.
REQ-019 Controls SHALL be combinational from state, opcode, flags and mem_ack; mem_req SHALL stay high until ack and drop the cycle after it.
REQ-020 instr_cnt SHALL increment by 1 when a JMP/JGE/JNE leaves DECODE, when an EXEC access is acknowledged, and on entry to HALT; it SHALL wrap from 2^CNTW-1 to 0.
REQ-021 A timeout counter SHALL clear when mem_req is low or mem_ack is high, count otherwise, and at TIMEOUT consecutive unacknowledged cycles -> ERR (access abandoned, no ir_ld/acc_ld).
REQ-022 HALT: halted=1, controls 0; start=1 -> FETCH (PC already past STP).
REQ-023 ERR: error=1, controls 0; exits only via reset; start ignored.
REQ-024 start SHALL be ignored outside IDLE and HALT.

Reset
REQ-025 reset=1 SHALL force IDLE, clear instr_cnt and the timeout counter and drive all outputs 0 on the following cycle, including mid-access; reset has priority over start and mem_ack.

Configuration
REQ-026 With macro MU0_CTRL_STEP_EN defined, input single_step (1 bit) SHALL exist; if single_step=1 at a retirement that would go to FETCH, the FSM SHALL go to IDLE instead; start resumes. Without the macro the port is absent and retirement always proceeds to FETCH.

Verification
REQ-027 Reset, start, memory acks in 1 cycle, program LDA 0x010 / ADD 0x011 / STO 0x012 / STP -> acc_ld with alu_fn 00 then 01, mem_we=1 with addr_sel=1 for STO, halted=1, instr_cnt=4.
REQ-028 JNE with acc_zero=0 then acc_zero=1; JGE with acc_neg=1 -> pc_ld=1, 0, 0 respectively in DECODE; each returns to FETCH next cycle.
REQ-029 Fetch ack delayed 14 cycles -> no error, ir_ld in ack cycle; ack withheld 15 cycles -> error=1, state ERR, start has no effect.
REQ-030 Opcode 0x9 fetched -> error=1 after DECODE; reset then start -> fetch resumes, instr_cnt=0.
REQ-031 reset asserted during EXEC with mem_req=1 -> next cycle mem_req=0, all outputs 0, IDLE; preset instr_cnt 0xFFFF + one retirement -> 0x0000.
REQ-032 MU0_CTRL_STEP_EN defined, single_step=1 -> after each retired instruction IDLE, one instruction per start pulse.

Source files
------------

// File: rtl/mu0_ctrl.sv
// MU0 control FSM (fetch/decode/exec) with memory timeout and a retired-instruction counter; optional single-step via MU0_CTRL_STEP_EN.
// Latency: controls are combinational from state/opcode/flags/mem_ack. Backpressure: each access holds mem_req until mem_ack arrives or TIMEOUT expires.
module mu0_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNTW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      opcode,
   input  logic            acc_zero,
   input  logic            acc_neg,
   input  logic            mem_ack,
`ifdef MU0_CTRL_STEP_EN
   input  logic            single_step,
`endif
   output logic            mem_req,
   output logic            mem_we,
   output logic            addr_sel,
   output logic            ir_ld,
   output logic            pc_inc,
   output logic            pc_ld,
   output logic            acc_ld,
   output logic [1:0]      alu_fn,
   output logic            halted,
   output logic            error,
   output logic [CNTW-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_ERR
   } state_t;

   localparam logic [3:0] OP_LDA = 4'd0, OP_STO = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                          OP_JMP = 4'd4, OP_JGE = 4'd5, OP_JNE = 4'd6, OP_STP = 4'd7;

   state_t     state, state_nxt;
   logic [7:0] to_cnt;
   logic       to_hit;
   logic       retire;
   logic       step_stop;
   state_t     resume;

`ifdef MU0_CTRL_STEP_EN
   assign step_stop = single_step;
`else
   assign step_stop = 1'b0;
`endif

   // A retirement that would refetch parks in IDLE instead when single-stepping.
   assign resume = step_stop ? S_IDLE : S_FETCH;
   assign to_hit = mem_req && !mem_ack && (to_cnt == 8'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_ld     = 1'b0;
      pc_inc    = 1'b0;
      pc_ld     = 1'b0;
      acc_ld    = 1'b0;
      alu_fn    = 2'b00;
      halted    = 1'b0;
      error     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_ld     = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = S_DECODE;
            end else if (to_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LDA, OP_STO, OP_ADD, OP_SUB: state_nxt = S_EXEC;
               OP_JMP: begin pc_ld = 1'b1;      retire = 1'b1; state_nxt = resume; end
               OP_JGE: begin pc_ld = !acc_neg;  retire = 1'b1; state_nxt = resume; end
               OP_JNE: begin pc_ld = !acc_zero; retire = 1'b1; state_nxt = resume; end
               OP_STP: begin retire = 1'b1; state_nxt = S_HALT; end
               default: state_nxt = S_ERR;
            endcase
         end
         S_EXEC: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_STO);
            if (mem_ack) begin
               retire    = 1'b1;
               state_nxt = resume;
               case (opcode)
                  OP_LDA: begin acc_ld = 1'b1; alu_fn = 2'b00; end
                  OP_ADD: begin acc_ld = 1'b1; alu_fn = 2'b01; end
                  OP_SUB: begin acc_ld = 1'b1; alu_fn = 2'b10; end
                  default: ;
               endcase
            end else if (to_hit) begin
               state_nxt = S_ERR;
            end
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_nxt = S_FETCH;
         end
         S_ERR: begin
            error = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         to_cnt    <= 8'd0;
         instr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (retire) instr_cnt <= instr_cnt + CNTW'(1);
         // Counts consecutive unacknowledged request cycles only.
         if (!mem_req || mem_ack) to_cnt <= 8'd0;
         else                     to_cnt <= to_cnt + 8'd1;
      end
   end

endmodule
